// File: rtl/act_lut_loader.sv
// Loads one mask-selected segment of the activation LUT from a valid/ready word stream
// and arbitrates the shared activation unit between evaluations and reprogramming.
module act_lut_loader #(
    parameter int unsigned MASK_SIZE = 4,
    parameter int unsigned LUT_DEPTH = 4,
    parameter int unsigned LUT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [MASK_SIZE-1:0]           start_mask,
    input  logic                           abort,
    input  logic                           s_valid,
    input  logic [LUT_WIDTH-1:0]           s_data,
    output logic                           s_ready,
    input  logic                           eval_req,
    output logic                           eval_gnt,
    output logic                           lut_write_enable,
    output logic [MASK_SIZE+LUT_DEPTH-1:0] lut_write_addr,
    output logic [LUT_WIDTH-1:0]           lut_write_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned ADDR_W = MASK_SIZE + LUT_DEPTH;
    localparam logic [LUT_DEPTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [LUT_DEPTH-1:0]   index, index_d;
    logic [MASK_SIZE-1:0]   mask, mask_d;
    logic                   we_d, done_d, err_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [LUT_WIDTH-1:0]   data_d;
    logic                   beat;

    assign s_ready  = (state == LOAD);
    assign beat     = s_ready & s_valid;
    assign busy     = (state != IDLE);
    // start wins the unit over a same-cycle evaluation request
    assign eval_gnt = (state == IDLE) & eval_req & ~start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            index            <= '0;
            mask             <= '0;
            lut_write_enable <= 1'b0;
            lut_write_addr   <= '0;
            lut_write_data   <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_d;
            index            <= index_d;
            mask             <= mask_d;
            lut_write_enable <= we_d;
            lut_write_addr   <= addr_d;
            lut_write_data   <= data_d;
            done             <= done_d;
            err              <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        index_d = index;
        mask_d  = mask;
        we_d    = 1'b0;
        addr_d  = lut_write_addr;
        data_d  = lut_write_data;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_d  = start_mask;
                    index_d = '0;
                    state_d = DRAIN;
                end
            end
            // one idle cycle lets an evaluation granted last cycle leave the unit
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = {mask, index};
                    data_d  = s_data;
                    index_d = index + LUT_DEPTH'(1);
                end
                // an abort still lets a same-cycle beat reach the LUT, but suppresses done
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (beat && (index == LAST_IDX)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Bench for act_lut_loader: event-scheduled reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_act_lut_loader;

    localparam int unsigned MS = 4;
    localparam int unsigned LD = 4;
    localparam int unsigned LW = 32;
    localparam int unsigned AW = MS + LD;
    localparam int          SEG = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [MS-1:0] start_mask = '0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [LW-1:0] s_data = '0;
    logic          s_ready;
    logic          eval_req = 1'b0;
    logic          eval_gnt;
    logic          lut_write_enable;
    logic [AW-1:0] lut_write_addr;
    logic [LW-1:0] lut_write_data;
    logic          busy;
    logic          done;
    logic          err;

    act_lut_loader #(.MASK_SIZE(MS), .LUT_DEPTH(LD), .LUT_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_mask(start_mask), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .eval_req(eval_req), .eval_gnt(eval_gnt),
        .lut_write_enable(lut_write_enable), .lut_write_addr(lut_write_addr),
        .lut_write_data(lut_write_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a job is a time window; beats schedule writes one cycle later,
    // the sixteenth beat schedules done two cycles later, abort schedules err one later.
    bit            m_active, m_last, m_open, m_beat;
    int            m_start, m_end, m_beats;
    logic [MS-1:0] m_mask;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;
    logic [AW-1:0] wr_addr [int];
    logic [LW-1:0] wr_data [int];
    bit            done_at [int];
    bit            err_at  [int];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_last = 1'b0; m_addr = '0; m_data = '0;
            wr_addr.delete(); wr_data.delete(); done_at.delete(); err_at.delete();
            chk("rst_ready", 64'(s_ready), 0);
            chk("rst_gnt", 64'(eval_gnt), 0);
            chk("rst_we", 64'(lut_write_enable), 0);
            chk("rst_addr", 64'(lut_write_addr), 0);
            chk("rst_data", 64'(lut_write_data), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_done", 64'(done), 0);
            chk("rst_err", 64'(err), 0);
        end else begin
            if (m_active && cyc >= m_end) m_active = 1'b0;
            if (wr_addr.exists(cyc)) begin
                m_addr = wr_addr[cyc];
                m_data = wr_data[cyc];
            end
            m_open = m_active && (cyc >= m_start + 2) && !m_last;
            chk("we", 64'(lut_write_enable), 64'(wr_addr.exists(cyc)));
            chk("addr", 64'(lut_write_addr), 64'(m_addr));
            chk("data", 64'(lut_write_data), 64'(m_data));
            chk("done", 64'(done), 64'(done_at.exists(cyc)));
            chk("err", 64'(err), 64'(err_at.exists(cyc)));
            chk("s_ready", 64'(s_ready), 64'(m_open));
            chk("busy", 64'(busy), 64'(m_active));
            chk("eval_gnt", 64'(eval_gnt), 64'(!m_active && eval_req && !start));
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_start = cyc; m_mask = start_mask;
                    m_beats = 0; m_last = 1'b0; m_end = 32'h7fff_ffff;
                end
            end else begin
                m_beat = m_open && s_valid;
                if (m_beat) begin
                    wr_addr[cyc+1] = AW'(int'(m_mask) * SEG + m_beats);
                    wr_data[cyc+1] = s_data;
                    m_beats++;
                end
                if (abort && !m_last) begin
                    err_at[cyc+1] = 1'b1;
                    m_end = cyc + 1;
                end else if (m_beat && m_beats == SEG) begin
                    m_last = 1'b1;
                    done_at[cyc+2] = 1'b1;
                    m_end = cyc + 2;
                end
            end
        end
        cyc++;
    end

    // Transaction monitor feeding the directed literal checks
    logic [AW-1:0] mon_addr [$];
    logic [LW-1:0] mon_data [$];
    int            mon_wcyc [$];
    int            mon_done [$];
    int            mon_err  [$];
    bit            gnt_at_done, gnt_at_err, first_gnt;
    int            mcyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lut_write_enable) begin
                mon_addr.push_back(lut_write_addr);
                mon_data.push_back(lut_write_data);
                mon_wcyc.push_back(mcyc);
            end
            if (done) begin mon_done.push_back(mcyc); gnt_at_done = eval_gnt; end
            if (err)  begin mon_err.push_back(mcyc);  gnt_at_err  = eval_gnt; end
        end
        mcyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_addr.delete(); mon_data.delete(); mon_wcyc.delete();
        mon_done.delete(); mon_err.delete();
        gnt_at_done = 1'b0; gnt_at_err = 1'b0;
    endtask

    // gap=1 gives the 1,0,0 valid pattern; abort_after>=0 aborts once that many beats are in
    task automatic do_load(input logic [MS-1:0] mask, input bit gap, input int abort_after,
                           input logic [LW-1:0] base, input bit restart_mid);
        int sent = 0;
        int pat = 0;
        int budget = 300;
        start = 1'b1; start_mask = mask;
        #1 first_gnt = eval_gnt;
        tick();
        start = 1'b0;
        while (busy && budget > 0) begin
            s_valid = 1'b0; abort = 1'b0; start = 1'b0;
            if (s_ready) begin
                if (abort_after >= 0 && sent == abort_after) begin
                    abort = 1'b1;
                end else if (sent < SEG) begin
                    if (!gap || pat % 3 == 0) begin
                        s_valid = 1'b1; s_data = base + LW'(sent); sent++;
                    end
                    pat++;
                    if (restart_mid && sent == 4) begin
                        start = 1'b1; start_mask = mask ^ MS'(5);
                    end
                end
            end
            tick();
            budget--;
        end
        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        chk("load_timeout", 64'(busy), 0);
        tick();
    endtask

    task automatic chk_seg(input string nm, input logic [MS-1:0] mask, input int n,
                           input logic [LW-1:0] base);
        chk({nm, "_nwrites"}, 64'(mon_addr.size()), 64'(n));
        for (int i = 0; i < n && i < mon_addr.size(); i++) begin
            chk({nm, "_addr"}, 64'(mon_addr[i]), 64'(int'(mask) * SEG + i));
            chk({nm, "_data"}, 64'(mon_data[i]), 64'(base + LW'(i)));
        end
    endtask

    initial begin
        int sent;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full back-to-back load into segment 2
        clear_mon();
        do_load(MS'(2), 1'b0, -1, 32'h100, 1'b0);
        chk_seg("full", MS'(2), SEG, 32'h100);
        chk("full_span", 64'(mon_wcyc[SEG-1] - mon_wcyc[0]), 15);
        chk("full_ndone", 64'(mon_done.size()), 1);
        chk("full_done_lat", 64'(mon_done[0] - mon_wcyc[SEG-1]), 1);
        chk("full_nerr", 64'(mon_err.size()), 0);

        // Gapped stream into segment 15
        clear_mon();
        do_load(MS'(15), 1'b1, -1, 32'h5000, 1'b0);
        chk_seg("gap", MS'(15), SEG, 32'h5000);
        chk("gap_span", 64'(mon_wcyc[SEG-1] - mon_wcyc[0]), 45);
        chk("gap_ndone", 64'(mon_done.size()), 1);

        // start beats a simultaneous eval_req; the held request is granted on done
        clear_mon();
        eval_req = 1'b1;
        do_load(MS'(1), 1'b0, -1, 32'h77, 1'b0);
        chk("prio_gnt_on_start", 64'(first_gnt), 0);
        chk("prio_gnt_at_done", 64'(gnt_at_done), 1);

        // Abort after seven beats, evaluation resumes with err
        clear_mon();
        do_load(MS'(6), 1'b0, 7, 32'hA00, 1'b0);
        chk_seg("abort", MS'(6), 7, 32'hA00);
        chk("abort_nerr", 64'(mon_err.size()), 1);
        chk("abort_ndone", 64'(mon_done.size()), 0);
        chk("abort_gnt", 64'(gnt_at_err), 1);
        eval_req = 1'b0;

        // start during LOAD is ignored
        clear_mon();
        do_load(MS'(2), 1'b0, -1, 32'h300, 1'b1);
        chk_seg("restart", MS'(2), SEG, 32'h300);
        chk("restart_ndone", 64'(mon_done.size()), 1);

        // Reset in the middle of a segment-3 load, then reload from index 0
        start = 1'b1; start_mask = MS'(3);
        tick();
        start = 1'b0; sent = 0;
        for (int b = 0; b < 40 && sent < 5; b++) begin
            s_valid = 1'b0;
            if (s_ready) begin s_valid = 1'b1; s_data = 32'hA0 + LW'(sent); sent++; end
            tick();
        end
        s_valid = 1'b0;
        tick();
        chk("pre_rst_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_ready", 64'(s_ready), 0);
        chk("async_rst_we", 64'(lut_write_enable), 0);
        chk("async_rst_addr", 64'(lut_write_addr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        do_load(MS'(3), 1'b0, -1, 32'hC0, 1'b0);
        chk_seg("reload", MS'(3), SEG, 32'hC0);

        // Randomized traffic, model-checked each cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; start = 1'b0; eval_req = 1'b0;
                abort = 1'b0; s_valid = 1'b0;
            end else begin
                rst_n      = 1'b1;
                start      = ($urandom_range(0, 9) == 0);
                start_mask = MS'($urandom);
                abort      = ($urandom_range(0, 59) == 0);
                s_valid    = ($urandom_range(0, 2) != 0);
                s_data     = $urandom;
                eval_req   = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; eval_req = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
